// File: rtl/spi_reg_ctrl_pkg.sv
// Shared types and constants for the SPI register-bank controller.
// Frame layout: {W, addr[6:0], data[7:0]}, MSB first.
package spi_reg_pkg;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] DECODE = 2'd1;
    localparam logic [1:0] EXEC   = 2'd2;
    localparam logic [1:0] RESP   = 2'd3;

    localparam int W_BIT    = 15;
    localparam int ADDR_MSB = 14;
    localparam int ADDR_LSB = 8;

    localparam logic [7:0] CLEAR_KEY = 8'hA5;
    localparam logic [6:0] RO_LAST   = 7'd1;

    typedef struct packed {
        logic       w;
        logic [6:0] addr;
        logic [7:0] data;
    } cmd_t;

    typedef struct packed {
        logic       err;
        logic       w;
        logic       bad;
        logic [4:0] cnt;
        logic [7:0] rdata;
    } resp_t;

    function automatic cmd_t split_frame(
        input logic [15:0] f
    );
        cmd_t c;
        c.w    = f[W_BIT];
        c.addr = f[ADDR_MSB:ADDR_LSB];
        c.data = f[ADDR_LSB-1:0];
        return c;
    endfunction

endpackage

// File: rtl/spi_reg_ctrl_if.sv
// Word-level link between the SPI slave engine and the register controller.
// The engine (master modport) presents frames; the controller answers.
interface spi_reg_ctrl_if #(
    parameter int FRAME_W = 16
);

    logic [FRAME_W-1:0] frame_in;
    logic               frame_ready;
    logic [FRAME_W-1:0] frame_out;

    modport master (
        output frame_in,
        output frame_ready,
        input  frame_out
    );

    modport slave (
        input  frame_in,
        input  frame_ready,
        output frame_out
    );

endinterface

// File: rtl/spi_reg_ctrl_bank.sv
// Register array with one write port and a read mux that overlays
// the ID constant at address 0 and live status at address 1.
module spi_reg_bank
    import spi_reg_pkg::*;
#(
    parameter int         NREGS    = 16,
    parameter logic [7:0] ID_VALUE = 8'h5A
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               we,
    input  logic [6:0]         waddr,
    input  logic [7:0]         wdata,
    input  logic [6:0]         raddr,
    input  logic [7:0]         hw_status,
    output logic [7:0]         rdata,
    output logic [NREGS*8-1:0] regs_flat
);

    localparam int AW = (NREGS > 1) ? $clog2(NREGS) : 1;
    localparam logic [7:0] NREGS_B = 8'(NREGS);

    logic [7:0] mem [NREGS];
    logic       w_ok;
    logic       r_ok;

    // Slots 0 and 1 are overlaid on read, so their storage never changes.
    assign w_ok = we
               && (waddr > RO_LAST)
               && ({1'b0, waddr} < NREGS_B);

    assign r_ok = (raddr > RO_LAST)
               && ({1'b0, raddr} < NREGS_B);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NREGS; k++) begin
                mem[k] <= '0;
            end
        end else if (w_ok) begin
            mem[waddr[AW-1:0]] <= wdata;
        end
    end

    always_comb begin
        rdata = 8'hFF;
        unique case (1'b1)
            (raddr == 7'd0):    rdata = ID_VALUE;
            (raddr == RO_LAST): rdata = hw_status;
            r_ok:               rdata = mem[raddr[AW-1:0]];
            default:            rdata = 8'hFF;
        endcase
    end

    for (genvar k = 0; k < NREGS; k++) begin : g_flat
        assign regs_flat[8*k +: 8] = mem[k];
    end

endmodule

// File: rtl/spi_reg_ctrl.sv
// Turns each SPI frame into a register read/write and stages the
// response word {err, W, bad, frame_cnt, rdata} for the next frame.
module spi_reg_ctrl
    import spi_reg_pkg::*;
#(
    parameter int         FRAME_W  = 16,
    parameter int         NREGS    = 16,
    parameter logic [7:0] ID_VALUE = 8'h5A
) (
    input  logic               clk,
    input  logic               rst_n,
    spi_reg_ctrl_if.slave      bus,
    input  logic [7:0]         hw_status,
    output logic [NREGS*8-1:0] regs_flat,
    output logic               wr_stb,
    output logic [6:0]         wr_addr,
    output logic [7:0]         wr_data,
    output logic               busy
);

    localparam logic [7:0] NREGS_B = 8'(NREGS);

    logic [1:0]         state;
    logic               rdy_q;
    cmd_t               cmd_q;
    logic               bad_q;
    logic               err_q;
    logic [4:0]         cnt_q;
    logic [7:0]         rdata_q;
    logic [FRAME_W-1:0] fo_q;

    logic       rise;
    logic       is_key;
    logic       bad_c;
    logic       bank_we;
    logic [7:0] bank_rdata;
    logic [4:0] cnt_nxt;
    resp_t      resp;

    assign rise = bus.frame_ready & ~rdy_q;

    // The clear key is the one legal write into the read-only window.
    assign is_key = cmd_q.w
                 && (cmd_q.addr == 7'd0)
                 && (cmd_q.data == CLEAR_KEY);

    assign bad_c = ({1'b0, cmd_q.addr} >= NREGS_B)
                || (cmd_q.w
                    && (cmd_q.addr <= RO_LAST)
                    && !is_key);

    assign bank_we = (state == EXEC)
                  && cmd_q.w
                  && !bad_q
                  && !is_key;

    assign cnt_nxt = cnt_q + 5'd1;

    always_comb begin
        resp.err   = err_q;
        resp.w     = cmd_q.w;
        resp.bad   = bad_q;
        resp.cnt   = cnt_nxt;
        resp.rdata = rdata_q;
    end

    assign bus.frame_out = fo_q;
    assign busy          = (state != IDLE);

    spi_reg_bank #(
        .NREGS    (NREGS),
        .ID_VALUE (ID_VALUE)
    ) u_bank (
        .clk       (clk),
        .rst_n     (rst_n),
        .we        (bank_we),
        .waddr     (cmd_q.addr),
        .wdata     (cmd_q.data),
        .raddr     (cmd_q.addr),
        .hw_status (hw_status),
        .rdata     (bank_rdata),
        .regs_flat (regs_flat)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            rdy_q   <= 1'b1;
            cmd_q   <= '0;
            bad_q   <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
            rdata_q <= '0;
            fo_q    <= '0;
            wr_stb  <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
        end else begin
            rdy_q  <= bus.frame_ready;
            wr_stb <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (rise) begin
                        cmd_q <= split_frame(
                            bus.frame_in[15:0]);
                        state <= DECODE;
                    end
                end
                DECODE: begin
                    bad_q <= bad_c;
                    state <= EXEC;
                end
                EXEC: begin
                    state <= RESP;
                    if (bad_q) begin
                        err_q   <= 1'b1;
                        rdata_q <= 8'hFF;
                    end else if (cmd_q.w) begin
                        wr_stb  <= 1'b1;
                        wr_addr <= cmd_q.addr;
                        wr_data <= cmd_q.data;
                        rdata_q <= cmd_q.data;
                        if (is_key) begin
                            err_q <= 1'b0;
                            cnt_q <= '0;
                        end
                    end else begin
                        rdata_q <= bank_rdata;
                    end
                end
                RESP: begin
                    fo_q  <= FRAME_W'(resp);
                    cnt_q <= cnt_nxt;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
